req_arb: RTL and testbench

Two-master arbiter for the split request/write/read stream bus used between the CPU interface and the memory side (`req_mux` → `req_sdram` / `req_wb_bridge`). It lets a second bus master (DMA engine: audio, SD or Ethernet block transfers) share the single downstream port with `cpuif`. It grants one complete transaction at a time and forwards its write and read beats. It sits between the masters and `req_mux`, and is transparent to the slaves.

---
 rtl/req_pkg.sv | 19 +
 rtl/rr_pick.sv | 18 +
 rtl/req_arb.sv | 153 +++++++++++++++
 tb/tb_req_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_pkg.sv
// Shared definitions for the request/write/read stream bus arbiter.
package req_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    // Default width of req_len (beats = len + 1)
    localparam int LEN_W_DEF = 3;

    // Beat count of a transaction from its len field. Wide enough for any
    // practical LEN_W; callers narrow the result to their counter width.
    function automatic logic [16:0] beats_from_len(input logic [15:0] len);
        return {1'b0, len} + 17'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way grant picker; the result is registered by req_arb.
module rr_pick #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // A lone requester always wins; a tie goes to the master that did not
    // win last time (round-robin) or to m0 (fixed priority).
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11)
            gnt_o = (RR && !last_i) ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/req_arb.sv
// Two-master arbiter for the split request/write/read stream bus. Grants one
// whole transaction at a time and forwards its beats combinationally.
module req_arb
    import req_pkg::*;
#(
    parameter bit RR    = 1'b1,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             m0_req_valid,
    output logic             m0_req_ready,
    input  logic             m0_req_we,
    input  logic [LEN_W-1:0] m0_req_len,
    input  logic [3:0]       m0_req_mask,
    input  logic [31:0]      m0_req_addr,
    input  logic             m0_write_valid,
    input  logic [31:0]      m0_write_data,
    output logic             m0_read_valid,
    output logic [31:0]      m0_read_data,
    input  logic             m0_read_ack,

    input  logic             m1_req_valid,
    output logic             m1_req_ready,
    input  logic             m1_req_we,
    input  logic [LEN_W-1:0] m1_req_len,
    input  logic [3:0]       m1_req_mask,
    input  logic [31:0]      m1_req_addr,
    input  logic             m1_write_valid,
    input  logic [31:0]      m1_write_data,
    output logic             m1_read_valid,
    output logic [31:0]      m1_read_data,
    input  logic             m1_read_ack,

    output logic             s_req_valid,
    input  logic             s_req_ready,
    output logic             s_req_we,
    output logic [LEN_W-1:0] s_req_len,
    output logic [3:0]       s_req_mask,
    output logic [31:0]      s_req_addr,
    output logic             s_write_valid,
    output logic [31:0]      s_write_data,
    input  logic             s_read_valid,
    input  logic [31:0]      s_read_data,
    output logic             s_read_ack,

    output logic [1:0]       gnt_o
);

    localparam int CNT_W = LEN_W + 1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;     // 1 = m1 won the previous grant
    logic [CNT_W-1:0] cnt_q, cnt_d;       // beats left in the current data phase
    logic [1:0]       pick;
    logic             sel;                // 1 = m1 owns the bus

    assign sel = gnt_q[1];

    rr_pick #(.RR(RR)) u_pick (
        .req_i  ({m1_req_valid, m0_req_valid}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Read data is broadcast; only the owner sees read_valid.
    assign m0_read_data = s_read_data;
    assign m1_read_data = s_read_data;
    assign gnt_o        = gnt_q;

    // Steer the owner's request/write fields downstream and gate handshakes by state
    always_comb begin
        s_req_we      = sel ? m1_req_we     : m0_req_we;
        s_req_len     = sel ? m1_req_len    : m0_req_len;
        s_req_mask    = sel ? m1_req_mask   : m0_req_mask;
        s_req_addr    = sel ? m1_req_addr   : m0_req_addr;
        s_write_data  = sel ? m1_write_data : m0_write_data;

        s_req_valid   = (state_q == ST_REQ)   && (sel ? m1_req_valid : m0_req_valid);
        m0_req_ready  = (state_q == ST_REQ)   && gnt_q[0] && s_req_ready;
        m1_req_ready  = (state_q == ST_REQ)   && gnt_q[1] && s_req_ready;

        s_write_valid = (state_q == ST_WDATA) && (sel ? m1_write_valid : m0_write_valid);

        s_read_ack    = (state_q == ST_RDATA) && (sel ? m1_read_ack : m0_read_ack);
        m0_read_valid = (state_q == ST_RDATA) && gnt_q[0] && s_read_valid;
        m1_read_valid = (state_q == ST_RDATA) && gnt_q[1] && s_read_valid;
    end

    // Transaction sequencing: grant, request handshake, then count beats out.
    // The data state itself records the direction, so no separate we flop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    gnt_d   = pick;
                    last_d  = pick[1];
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (s_req_valid && s_req_ready) begin
                    cnt_d   = CNT_W'(beats_from_len(16'(s_req_len)));
                    state_d = s_req_we ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (s_write_valid) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        gnt_d   = 2'b00;
                    end
                end
            end
            ST_RDATA: begin
                if (s_read_valid && s_read_ack) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        gnt_d   = 2'b00;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State registers; last starts at m1 so m0 wins the first tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_req_arb.sv
// Scoreboard bench for req_arb: a round-robin instance is fully checked and a
// fixed-priority instance sharing the same inputs is checked for grant order.
module tb_req_arb;

    localparam int LEN_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             m0_req_valid = 0, m0_req_we = 0, m0_write_valid = 0, m0_read_ack = 0;
    logic [LEN_W-1:0] m0_req_len = 0;
    logic [3:0]       m0_req_mask = 0;
    logic [31:0]      m0_req_addr = 0, m0_write_data = 0;
    logic             m1_req_valid = 0, m1_req_we = 0, m1_write_valid = 0, m1_read_ack = 0;
    logic [LEN_W-1:0] m1_req_len = 0;
    logic [3:0]       m1_req_mask = 0;
    logic [31:0]      m1_req_addr = 0, m1_write_data = 0;
    logic             s_req_ready = 1, s_read_valid = 0;
    logic [31:0]      s_read_data = 0;

    // round-robin instance outputs
    logic             m0_req_ready, m0_read_valid, m1_req_ready, m1_read_valid;
    logic [31:0]      m0_read_data, m1_read_data;
    logic             s_req_valid, s_req_we, s_write_valid, s_read_ack;
    logic [LEN_W-1:0] s_req_len;
    logic [3:0]       s_req_mask;
    logic [31:0]      s_req_addr, s_write_data;
    logic [1:0]       gnt_o;

    // fixed-priority instance outputs
    logic             f_m0_req_ready, f_m0_read_valid, f_m1_req_ready, f_m1_read_valid;
    logic [31:0]      f_m0_read_data, f_m1_read_data;
    logic             f_s_req_valid, f_s_req_we, f_s_write_valid, f_s_read_ack;
    logic [LEN_W-1:0] f_s_req_len;
    logic [3:0]       f_s_req_mask;
    logic [31:0]      f_s_req_addr, f_s_write_data;
    logic [1:0]       f_gnt_o;

    req_arb #(.RR(1'b1), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_len(m0_req_len), .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr),
        .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
        .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_len(m1_req_len), .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr),
        .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
        .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_len(s_req_len), .s_req_mask(s_req_mask), .s_req_addr(s_req_addr),
        .s_write_valid(s_write_valid), .s_write_data(s_write_data),
        .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(s_read_ack),
        .gnt_o(gnt_o)
    );

    req_arb #(.RR(1'b0), .LEN_W(LEN_W)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(f_m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_len(m0_req_len), .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr),
        .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
        .m0_read_valid(f_m0_read_valid), .m0_read_data(f_m0_read_data), .m0_read_ack(m0_read_ack),
        .m1_req_valid(m1_req_valid), .m1_req_ready(f_m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_len(m1_req_len), .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr),
        .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
        .m1_read_valid(f_m1_read_valid), .m1_read_data(f_m1_read_data), .m1_read_ack(m1_read_ack),
        .s_req_valid(f_s_req_valid), .s_req_ready(s_req_ready), .s_req_we(f_s_req_we),
        .s_req_len(f_s_req_len), .s_req_mask(f_s_req_mask), .s_req_addr(f_s_req_addr),
        .s_write_valid(f_s_write_valid), .s_write_data(f_s_write_data),
        .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(f_s_read_ack),
        .gnt_o(f_gnt_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic half();
        @(negedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Wait (bounded) for the given master to see req_ready
    task automatic wait_rdy(input bit m);
        int n = 0;
        half();
        while (!(m ? m1_req_ready : m0_req_ready) && n < 20) begin
            half();
            n++;
        end
        chk(m ? "rdy_m1" : "rdy_m0", {31'd0, m ? m1_req_ready : m0_req_ready}, 32'd1);
    endtask

    // scoreboards
    logic [31:0] wq[$];      // expected s_write_data beats
    logic [31:0] rq0[$];     // expected m0 read beats
    logic [31:0] rq1[$];     // expected m1 read beats
    logic [1:0]  gq[$];      // expected grant order, round-robin instance
    logic [1:0]  gq_fp[$];   // expected grant order, fixed-priority instance
    bit          chk_gnt = 0;
    int          gcnt = 0;
    logic [1:0]  prev_g = 0, prev_fg = 0;

    // Monitor: pop expectations whenever the DUT produces a beat or a grant
    always @(negedge clk) begin
        if (s_write_valid) begin
            if (wq.size() == 0) chk("wr_extra", {31'd0, s_write_valid}, 32'd0);
            else                chk("wr_data", s_write_data, wq.pop_front());
        end
        if (m0_read_valid && m0_read_ack) begin
            if (rq0.size() == 0) chk("rd0_extra", {31'd0, m0_read_valid}, 32'd0);
            else                 chk("rd0_data", m0_read_data, rq0.pop_front());
        end
        if (m1_read_valid && m1_read_ack) begin
            if (rq1.size() == 0) chk("rd1_extra", {31'd0, m1_read_valid}, 32'd0);
            else                 chk("rd1_data", m1_read_data, rq1.pop_front());
        end
        if (!gnt_o[1]) chk("m1_rv_ng", {31'd0, m1_read_valid}, 32'd0);
        if (chk_gnt && prev_g == 2'b00 && gnt_o != 2'b00) begin
            gcnt++;
            if (gq.size() == 0) chk("gnt_extra", {30'd0, gnt_o}, 32'd0);
            else                chk("gnt_rr", {30'd0, gnt_o}, {30'd0, gq.pop_front()});
        end
        if (chk_gnt && prev_fg == 2'b00 && f_gnt_o != 2'b00) begin
            if (gq_fp.size() == 0) chk("gnt_fp_extra", {30'd0, f_gnt_o}, 32'd0);
            else                   chk("gnt_fp", {30'd0, f_gnt_o}, {30'd0, gq_fp.pop_front()});
        end
        prev_g  = gnt_o;
        prev_fg = f_gnt_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        repeat (2) half();
        chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rst_sreqv", {31'd0, s_req_valid}, 32'd0);
        chk("rst_rdy", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
        chk("rst_wv", {31'd0, s_write_valid}, 32'd0);
        chk("rst_ack", {31'd0, s_read_ack}, 32'd0);
        step();
        rst = 1'b0;

        // single read from m0, len 3
        m0_req_we = 0; m0_req_len = 3; m0_req_addr = 32'h8000_0000; m0_req_mask = 4'hF;
        m0_req_valid = 1;
        for (int i = 0; i < 4; i++) rq0.push_back(32'hA0 + i);
        half();
        chk("rd_lat0", {31'd0, s_req_valid}, 32'd0);
        chk("rd_rdy0", {31'd0, m0_req_ready}, 32'd0);
        half();
        chk("rd_lat1", {31'd0, s_req_valid}, 32'd1);
        chk("rd_gnt", {30'd0, gnt_o}, 32'd1);
        chk("rd_addr", s_req_addr, 32'h8000_0000);
        chk("rd_len", {29'd0, s_req_len}, 32'd3);
        chk("rd_rdy", {31'd0, m0_req_ready}, 32'd1);
        step();
        m0_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            s_read_valid = 1; s_read_data = 32'hA0 + i; m0_read_ack = 1;
            half();
            chk("rd_ack", {31'd0, s_read_ack}, 32'd1);
            step();
        end
        s_read_valid = 0; m0_read_ack = 0;
        half();
        chk("rd_idle", {30'd0, gnt_o}, 32'd0);

        // single write from m1, len 0
        m1_req_we = 1; m1_req_len = 0; m1_req_mask = 4'hF; m1_req_addr = 32'h40; m1_req_valid = 1;
        wait_rdy(1);
        chk("wr_gnt", {30'd0, gnt_o}, 32'd2);
        chk("wr_we", {31'd0, s_req_we}, 32'd1);
        chk("wr_mask", {28'd0, s_req_mask}, 32'hF);
        step();
        m1_req_valid = 0;
        wq.push_back(32'hDEAD_BEEF);
        m1_write_valid = 1; m1_write_data = 32'hDEAD_BEEF;
        half();
        chk("wr_gnt_d", {30'd0, gnt_o}, 32'd2);
        step();
        m1_write_valid = 0;
        half();
        chk("wr_idle", {30'd0, gnt_o}, 32'd0);
        chk("wr_once", {31'd0, s_write_valid}, 32'd0);

        // simultaneous requests, one-beat writes from both masters
        chk_gnt = 1;
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        repeat (4) gq_fp.push_back(2'b01);
        wq.push_back(32'h1111_0000); wq.push_back(32'h2222_0000);
        wq.push_back(32'h1111_0000); wq.push_back(32'h2222_0000);
        m0_req_we = 1; m0_req_len = 0; m0_write_valid = 1; m0_write_data = 32'h1111_0000;
        m1_req_we = 1; m1_req_len = 0; m1_write_valid = 1; m1_write_data = 32'h2222_0000;
        m0_req_valid = 1; m1_req_valid = 1;
        n = 0;
        while (gcnt < 4 && n < 40) begin half(); n++; end
        chk("rr_gcnt", gcnt, 32'd4);
        half();
        n = 0;
        while (!s_write_valid && n < 10) begin half(); n++; end
        chk("rr_last_wv", {31'd0, s_write_valid}, 32'd1);
        step();
        m0_req_valid = 0; m1_req_valid = 0; m0_write_valid = 0; m1_write_valid = 0;
        half();
        chk_gnt = 0;
        chk("rr_idle", {30'd0, gnt_o}, 32'd0);
        chk("rr_gq", gq.size(), 32'd0);
        chk("fp_gq", gq_fp.size(), 32'd0);

        // contention: m1 read arrives during an 8-beat m0 write
        m0_req_we = 1; m0_req_len = 7; m0_req_addr = 32'h200; m0_req_valid = 1;
        wait_rdy(0);
        chk("ct_gnt", {30'd0, gnt_o}, 32'd1);
        step();
        m0_req_valid = 0;
        m1_req_we = 0; m1_req_len = 0; m1_req_addr = 32'h100; m1_req_valid = 1;
        for (int c = 0; c < 9; c++) begin
            m0_write_valid = (c != 4);
            m0_write_data  = 32'h3000_0000 + c;
            if (c != 4) wq.push_back(32'h3000_0000 + c);
            half();
            chk("ct_m1_rdy", {31'd0, m1_req_ready}, 32'd0);
            chk("ct_gnt_hold", {30'd0, gnt_o}, 32'd1);
            step();
        end
        m0_write_valid = 0;
        half();
        chk("ct_idle", {30'd0, gnt_o}, 32'd0);
        chk("ct_idle_rdy", {31'd0, m1_req_ready}, 32'd0);
        half();
        chk("ct_gnt_m1", {30'd0, gnt_o}, 32'd2);
        chk("ct_sreqv", {31'd0, s_req_valid}, 32'd1);
        chk("ct_addr", s_req_addr, 32'h100);
        step();
        m1_req_valid = 0;
        s_read_valid = 1; s_read_data = 32'hC0; m1_read_ack = 1;
        rq1.push_back(32'hC0);
        half();
        step();
        s_read_valid = 0; m1_read_ack = 0;
        half();
        chk("ct_done", {30'd0, gnt_o}, 32'd0);

        // read backpressure: slave valid, master withholds ack for 5 cycles
        m0_req_we = 0; m0_req_len = 1; m0_req_addr = 32'h300; m0_req_valid = 1;
        wait_rdy(0);
        step();
        m0_req_valid = 0;
        s_read_valid = 1; s_read_data = 32'hB0; m0_read_ack = 0;
        repeat (5) begin
            half();
            chk("bp_rv", {31'd0, m0_read_valid}, 32'd1);
            chk("bp_data", m0_read_data, 32'hB0);
            chk("bp_ack", {31'd0, s_read_ack}, 32'd0);
            step();
        end
        rq0.push_back(32'hB0); rq0.push_back(32'hB1);
        m0_read_ack = 1;
        half();
        step();
        s_read_data = 32'hB1;
        half();
        chk("bp_beat2", {31'd0, m0_read_valid}, 32'd1);
        step();
        s_read_valid = 0; m0_read_ack = 0;
        half();
        chk("bp_done", {30'd0, gnt_o}, 32'd0);

        // reset in RDATA with two beats left
        m0_req_we = 0; m0_req_len = 3; m0_req_addr = 32'h400; m0_req_valid = 1;
        wait_rdy(0);
        step();
        m0_req_valid = 0;
        rq0.push_back(32'hD0); rq0.push_back(32'hD1);
        for (int i = 0; i < 2; i++) begin
            s_read_valid = 1; s_read_data = 32'hD0 + i; m0_read_ack = 1;
            step();
        end
        chk("rs_pre", {31'd0, m0_read_valid}, 32'd1);
        rst = 1;
        #1;
        chk("rs_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rs_rv", {31'd0, m0_read_valid}, 32'd0);
        chk("rs_ack", {31'd0, s_read_ack}, 32'd0);
        chk("rs_sreqv", {31'd0, s_req_valid}, 32'd0);
        chk("rs_rdy", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
        chk("rs_wv", {31'd0, s_write_valid}, 32'd0);
        s_read_valid = 0; m0_read_ack = 0;
        step();
        rst = 0;
        m1_req_we = 1; m1_req_len = 1; m1_req_addr = 32'h500; m1_req_valid = 1;
        wait_rdy(1);
        chk("rs_gnt_m1", {30'd0, gnt_o}, 32'd2);
        step();
        m1_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            m1_write_valid = 1; m1_write_data = 32'hE0 + i;
            wq.push_back(32'hE0 + i);
            step();
        end
        m1_write_valid = 0;
        half();
        chk("rs_done", {30'd0, gnt_o}, 32'd0);

        chk("wq_empty", wq.size(), 32'd0);
        chk("rq0_empty", rq0.size(), 32'd0);
        chk("rq1_empty", rq1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
